debounce_multi: RTL and testbench
=================================

# debounce_multi

Parametrised multi-channel push-button conditioner. It replaces the single-channel fixed 3-sample debouncer in front-panel input paths. Each channel synchronises a raw asynchronous button, qualifies it with a programmable stable-time counter, and emits a clean level plus single-cycle press, release and long-press pulses. Its outputs feed the counter/display control logic directly.

## Interface
Parameters:
- N_CH, default 4: number of independent button channels (≥1).
- SYNC_STAGES, default 2: synchroniser flip-flops per channel (≥2).
- CNT_W, default 16: width of each per-channel counter.
- STABLE_CNT, default 20000: consecutive cycles of disagreement required to accept a new level. Range 2 ≤ STABLE_CNT ≤ 2^CNT_W−1.
- LONG_CNT, default 50000: cycles the accepted level must stay high before a long-press pulse. Range 1 ≤ LONG_CNT ≤ 2^CNT_W−1.

Ports:
- clk, input, 1: system clock. Everything is on the rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- btn, input, N_CH: raw button inputs, asynchronous, active-high.
- btn_clean, output, N_CH: debounced level per channel.
- press_pulse, output, N_CH: one-cycle pulse when btn_clean goes 0→1.
- release_pulse, output, N_CH: one-cycle pulse when btn_clean goes 1→0.
- long_pulse, output, N_CH: one-cycle pulse when a press has been held LONG_CNT cycles.

## Operation
- Channels are fully independent. Nothing is shared between them except clk and rst_n.
- Synchroniser: btn[i] passes through SYNC_STAGES flops. Call the last stage sync[i]. No other logic samples btn directly.
- Stable counter cnt[i] (CNT_W bits):
  - If sync[i] == btn_clean[i]: cnt[i] ← 0.
  - Else if cnt[i] == STABLE_CNT−1:
    - btn_clean[i] ← sync[i] and cnt[i] ← 0.
    - press_pulse[i] ← 1 if the new level is 1; release_pulse[i] ← 1 if it is 0.
  - Else: cnt[i] ← cnt[i]+1.
- Any single cycle of agreement restarts qualification. Glitches shorter than STABLE_CNT cycles are invisible.
- Long-press counter hold[i] (CNT_W bits):
  - Cleared whenever btn_clean[i] is 0.
  - Increments each cycle btn_clean[i] is 1. It saturates once it reaches LONG_CNT.
  - long_pulse[i] ← 1 for exactly the cycle in which hold[i] transitions LONG_CNT−1 → LONG_CNT.
  - At most one long_pulse per press. A release and a new qualified press re-arms it.
- Pulse outputs are registered and are high for exactly one cycle per event.
- press_pulse and release_pulse of the same channel are never high together.
- Counters never wrap: cnt is bounded by STABLE_CNT−1, hold saturates at LONG_CNT.

## Timing
- Reset (rst_n low, asynchronous) forces all of the following to 0 immediately:
  - synchroniser flops, cnt, hold
  - btn_clean, press_pulse, release_pulse, long_pulse
- Reset release: normal operation from the first rising edge with rst_n high.
- Latency: btn[i] changes and then stays stable. Count the first edge that samples it as edge 1.
  - btn_clean[i] and the matching press_pulse or release_pulse update on edge SYNC_STAGES+STABLE_CNT.
  - With defaults this is edge 20002.
- Long press: long_pulse[i] is high in the cycle following edge LONG_CNT counted after the edge that set btn_clean[i]=1. That is, it is asserted for the clock cycle that begins LONG_CNT cycles after btn_clean[i] rose.
- Release before LONG_CNT: no long_pulse. hold clears on the edge after btn_clean falls.
- Reset mid-press: all outputs drop immediately and no release_pulse is produced. If btn is still high after reset release, a full new qualification runs and press_pulse fires again.
- Simultaneous events on different channels occur in the same cycle without interaction.

## Test plan
Simulation parameters: N_CH=4, SYNC_STAGES=2, STABLE_CNT=4, LONG_CNT=10.
- Reset values: assert rst_n=0 mid-cycle with btn=4'hF. Required: all outputs 0 asynchronously, before the next clk edge.
- Clean press: btn[0] 0→1 and held. Required: btn_clean[0]=1 and press_pulse[0]=1 for one cycle, both at edge 6. Other channels stay quiet.
- Glitch rejection: btn[1] high for 3 cycles, then low; repeat 5 times. Required: btn_clean[1] stays 0 and no pulses.
- Release: btn[0] 1→0 after a qualified press. Required: release_pulse[0] one cycle at edge 6 after the change, and btn_clean[0]=0 from then on.
- Long press: hold btn[2] high for 30 cycles. Required: exactly one long_pulse[2], in the cycle 10 cycles after btn_clean[2] rose. A second 30-cycle press yields exactly one more.
- Mid-press reset and concurrency:
  - Press btn[0] and btn[3] on the same edge. Required: identical simultaneous press_pulses.
  - Then pulse rst_n low for 1 cycle while both are held. Required: outputs clear, no release_pulse, and fresh press_pulses at edge 6 after reset release.

Source files
------------

// File: rtl/debounce_multi.sv
// Multi-channel push-button conditioner: synchroniser, stable-time
// qualifier, and registered press/release/long-press pulses per channel.
module debounce_multi #(
    parameter int N_CH        = 4,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16,
    parameter int STABLE_CNT  = 20000,
    parameter int LONG_CNT    = 50000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] btn,
    output logic [N_CH-1:0] btn_clean,
    output logic [N_CH-1:0] press_pulse,
    output logic [N_CH-1:0] release_pulse,
    output logic [N_CH-1:0] long_pulse
);

    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CNT - 1);
    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CNT - 1);
    localparam logic [CNT_W-1:0] LONG_MAX    = CNT_W'(LONG_CNT);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic                   sync;
        logic [CNT_W-1:0]       cnt;
        logic [CNT_W-1:0]       hold;
        logic                   clean;
        logic                   press;
        logic                   rel;
        logic                   lng;

        assign sync = sync_q[SYNC_STAGES-1];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync_q <= '0;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], btn[i]};
            end
        end

        // Any cycle of agreement restarts qualification from zero.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt   <= '0;
                clean <= 1'b0;
                press <= 1'b0;
                rel   <= 1'b0;
            end else begin
                press <= 1'b0;
                rel   <= 1'b0;
                if (sync == clean) begin
                    cnt <= '0;
                end else if (cnt == STABLE_LAST) begin
                    cnt   <= '0;
                    clean <= sync;
                    press <= sync;
                    rel   <= ~sync;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end

        // hold saturates, so the pulse fires once per qualified press.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                hold <= '0;
                lng  <= 1'b0;
            end else if (!clean) begin
                hold <= '0;
                lng  <= 1'b0;
            end else begin
                lng <= (hold == LONG_LAST);
                if (hold != LONG_MAX) begin
                    hold <= hold + 1'b1;
                end
            end
        end

        assign btn_clean[i]     = clean;
        assign press_pulse[i]   = press;
        assign release_pulse[i] = rel;
        assign long_pulse[i]    = lng;
    end

endmodule

// File: tb/tb_debounce_multi.sv
// Bench for debounce_multi: directed sequences, a vector table and
// randomized stimulus against a sample-history reference model.
module tb_debounce_multi;

    localparam int N_CH   = 4;
    localparam int SYNC   = 2;
    localparam int CNT_W  = 16;
    localparam int STABLE = 4;
    localparam int LONG   = 10;
    localparam int D      = SYNC + STABLE;

    logic            clk   = 1'b0;
    logic            rst_n = 1'b1;
    logic [N_CH-1:0] btn   = '0;
    logic [N_CH-1:0] btn_clean;
    logic [N_CH-1:0] press_pulse;
    logic [N_CH-1:0] release_pulse;
    logic [N_CH-1:0] long_pulse;

    debounce_multi #(
        .N_CH(N_CH),
        .SYNC_STAGES(SYNC),
        .CNT_W(CNT_W),
        .STABLE_CNT(STABLE),
        .LONG_CNT(LONG)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .btn(btn),
        .btn_clean(btn_clean),
        .press_pulse(press_pulse),
        .release_pulse(release_pulse),
        .long_pulse(long_pulse)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    bit armed = 1'b0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reference model: hist[c][k] is btn sampled k edges ago. The level
    // flips once the last STABLE synchronised samples all disagree with it.
    bit [D-1:0]      hist [N_CH];
    bit [N_CH-1:0]   m_clean = '0;
    bit [N_CH-1:0]   m_press = '0;
    bit [N_CH-1:0]   m_rel   = '0;
    bit [N_CH-1:0]   m_long  = '0;
    int              age [N_CH];

    initial begin : model
        bit diff;
        for (int c = 0; c < N_CH; c++) begin
            hist[c] = '0;
            age[c]  = 0;
        end
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_clean = '0;
                m_press = '0;
                m_rel   = '0;
                m_long  = '0;
                for (int c = 0; c < N_CH; c++) begin
                    hist[c] = '0;
                    age[c]  = 0;
                end
            end else begin
                m_press = '0;
                m_rel   = '0;
                m_long  = '0;
                for (int c = 0; c < N_CH; c++) begin
                    hist[c] = {hist[c][D-2:0], btn[c]};
                    diff = 1'b1;
                    for (int k = SYNC; k < D; k++)
                        if (hist[c][k] == m_clean[c]) diff = 1'b0;
                    if (m_clean[c]) begin
                        if (age[c] <= LONG) age[c]++;
                        if (age[c] == LONG) m_long[c] = 1'b1;
                    end
                    if (diff) begin
                        m_clean[c] = ~m_clean[c];
                        if (m_clean[c]) begin
                            m_press[c] = 1'b1;
                            age[c]     = 0;
                        end else begin
                            m_rel[c] = 1'b1;
                        end
                    end
                end
            end
        end
    end

    initial begin : cycle_check
        forever begin
            @(negedge clk);
            if (armed)
                chk("cycle", 32'({btn_clean, press_pulse,
                                  release_pulse, long_pulse}),
                    32'({m_clean, m_press, m_rel, m_long}));
        end
    end

    typedef struct {
        logic [N_CH-1:0] btn;
        int              cycles;
        logic [N_CH-1:0] exp_clean;
    } vec_t;

    vec_t vecs [7];

    initial begin : stim
        int nlong;
        int at;
        int bad;
        vecs[0] = '{4'b0000, 8, 4'b0000};
        vecs[1] = '{4'b0101, 8, 4'b0101};
        vecs[2] = '{4'b1111, 3, 4'b0101};
        vecs[3] = '{4'b0110, 8, 4'b0110};
        vecs[4] = '{4'b1001, 5, 4'b0110};
        vecs[5] = '{4'b1001, 2, 4'b1001};
        vecs[6] = '{4'b0000, 7, 4'b0000};

        #2 rst_n = 1'b0;
        #20;
        armed = 1'b1;
        chk("reset_idle", 32'({btn_clean, press_pulse,
                               release_pulse, long_pulse}), 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Asynchronous reset mid-cycle with all buttons held
        btn = 4'hF;
        step(8);
        chk("all_held", 32'(btn_clean), 32'hF);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("async_reset", 32'({btn_clean, press_pulse,
                                release_pulse, long_pulse}), 32'h0);
        @(posedge clk);
        #1;
        btn   = '0;
        rst_n = 1'b1;
        step(2);

        // Clean press on channel 0
        btn[0] = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            step(1);
            chk($sformatf("press_e%0d", e),
                32'({btn_clean[0], press_pulse[0]}),
                32'(e < 6 ? 2'b00 : (e == 6 ? 2'b11 : 2'b10)));
            if (e == 6)
                chk("press_quiet",
                    32'({btn_clean[3:1], press_pulse[3:1],
                         release_pulse, long_pulse}), 32'h0);
        end

        // Release on channel 0
        btn[0] = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            step(1);
            chk($sformatf("release_e%0d", e),
                32'({btn_clean[0], release_pulse[0]}),
                32'(e < 6 ? 2'b10 : (e == 6 ? 2'b01 : 2'b00)));
        end

        // Glitch rejection on channel 1
        bad = 0;
        repeat (5) begin
            btn[1] = 1'b1;
            for (int k = 0; k < 3; k++) begin
                step(1);
                bad += int'(btn_clean[1] | press_pulse[1] | release_pulse[1]);
            end
            btn[1] = 1'b0;
            for (int k = 0; k < 3; k++) begin
                step(1);
                bad += int'(btn_clean[1] | press_pulse[1] | release_pulse[1]);
            end
        end
        chk("glitch", 32'(bad), 32'd0);

        // Two long presses on channel 2
        for (int p = 0; p < 2; p++) begin
            nlong  = 0;
            at     = 0;
            btn[2] = 1'b1;
            for (int e = 1; e <= 30; e++) begin
                step(1);
                if (long_pulse[2]) begin
                    nlong++;
                    at = e;
                end
            end
            chk($sformatf("long_count%0d", p), 32'(nlong), 32'd1);
            chk($sformatf("long_edge%0d", p), 32'(at), 32'd16);
            btn[2] = 1'b0;
            step(10);
        end

        // Simultaneous press, then reset while held
        btn = 4'b1001;
        step(6);
        chk("conc_press", 32'({btn_clean, press_pulse}), 32'h99);
        step(3);
        rst_n = 1'b0;
        #1;
        chk("mid_reset", 32'({btn_clean, press_pulse,
                              release_pulse, long_pulse}), 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        bad = 0;
        for (int e = 1; e <= 6; e++) begin
            step(1);
            bad += int'(|release_pulse);
            if (e < 6) bad += int'(|press_pulse);
        end
        chk("repress", 32'({btn_clean, press_pulse}), 32'h99);
        chk("no_release", 32'(bad), 32'd0);
        btn = '0;
        step(8);

        // Vector table
        for (int v = 0; v < 7; v++) begin
            btn = vecs[v].btn;
            step(vecs[v].cycles);
            chk($sformatf("vec%0d", v), 32'(btn_clean),
                32'(vecs[v].exp_clean));
        end

        // Random toggling against the model
        for (int i = 0; i < 800; i++) begin
            for (int c = 0; c < N_CH; c++)
                if ($urandom_range(0, 5) == 0) btn[c] = ~btn[c];
            if (i == 400) begin
                #1 rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end
            step(1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
